// File: rtl/alu_muldiv.sv
// alu_muldiv: EX-stage ALU with single-cycle arithmetic/logic/shift/compare
// ops and iterative unsigned multiply/divide, valid/ready on both sides.
module alu_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       ALUControl,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Res,
   output logic             Carry,
   output logic             OverFlow,
   output logic             Zero,
   output logic             Negative
);

   localparam int SHW = $clog2(WIDTH);
   localparam int CW  = SHW + 1;

   localparam logic [3:0] OP_ADD   = 4'b0000;
   localparam logic [3:0] OP_SUB   = 4'b0001;
   localparam logic [3:0] OP_AND   = 4'b0010;
   localparam logic [3:0] OP_OR    = 4'b0011;
   localparam logic [3:0] OP_XOR   = 4'b0100;
   localparam logic [3:0] OP_SLT   = 4'b0101;
   localparam logic [3:0] OP_SLTU  = 4'b0110;
   localparam logic [3:0] OP_SLL   = 4'b0111;
   localparam logic [3:0] OP_SRL   = 4'b1000;
   localparam logic [3:0] OP_SRA   = 4'b1001;
   localparam logic [3:0] OP_MUL   = 4'b1010;
   localparam logic [3:0] OP_MULHU = 4'b1011;
   localparam logic [3:0] OP_DIVU  = 4'b1100;
   localparam logic [3:0] OP_REMU  = 4'b1101;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;
   logic             neg_q, neg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [1:0]       mop_q, mop_d;

   logic             accept;
   logic             is_iter;
   logic             is_sub;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] alu_res;
   logic             alu_carry;
   logic             alu_ovf;
   logic [WIDTH:0]   mul_add;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH:0]   div_trial;
   logic [WIDTH-1:0] hi_n;
   logic [WIDTH-1:0] lo_n;
   logic [WIDTH-1:0] iter_res;
   logic             load_res;
   logic [WIDTH-1:0] new_res;
   logic             new_carry;
   logic             new_ovf;

   assign accept  = in_valid & in_ready;
   assign is_iter = (ALUControl >= OP_MUL) && (ALUControl <= OP_REMU);

   // Single-cycle ALU result and ADD/SUB flags from the live operands
   always_comb begin
      is_sub    = (ALUControl == OP_SUB);
      b_eff     = is_sub ? ~B : B;
      sum       = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
      shamt     = B[SHW-1:0];
      alu_res   = '0;
      alu_carry = 1'b0;
      alu_ovf   = 1'b0;
      case (ALUControl)
         OP_ADD, OP_SUB: begin
            alu_res   = sum[WIDTH-1:0];
            alu_carry = sum[WIDTH];
            alu_ovf   = (A[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
         end
         OP_AND:  alu_res = A & B;
         OP_OR:   alu_res = A | B;
         OP_XOR:  alu_res = A ^ B;
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
         OP_SLL:  alu_res = A << shamt;
         OP_SRL:  alu_res = A >> shamt;
         OP_SRA:  alu_res = $signed(A) >>> shamt;
         default: alu_res = '0;
      endcase
   end

   // One shift-add multiply step or one restoring divide step; the result
   // half (high product / remainder vs low product / quotient) is picked by mop_q[0]
   always_comb begin
      mul_add   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
      div_shift = {hi_q, lo_q[WIDTH-1]};
      div_trial = div_shift - {1'b0, opnd_q};
      if (mop_q[1]) begin
         if (!div_trial[WIDTH]) begin
            hi_n = div_trial[WIDTH-1:0];
            lo_n = {lo_q[WIDTH-2:0], 1'b1};
         end else begin
            hi_n = div_shift[WIDTH-1:0];
            lo_n = {lo_q[WIDTH-2:0], 1'b0};
         end
      end else begin
         hi_n = mul_add[WIDTH:1];
         lo_n = {mul_add[0], lo_q[WIDTH-1:1]};
      end
      iter_res = mop_q[0] ? hi_n : lo_n;
   end

   // State register and datapath flops, cleared by async active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         res_q   <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
         neg_q   <= 1'b0;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         opnd_q  <= '0;
         mop_q   <= '0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
         neg_q   <= neg_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         opnd_q  <= opnd_d;
         mop_q   <= mop_d;
      end
   end

   // Next-state logic: accepts from IDLE or on handoff in DONE, iterate in BUSY
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (in_valid) state_d = is_iter ? BUSY : DONE;
         end
         BUSY: begin
            if (cnt_q == CW'(1)) state_d = DONE;
         end
         DONE: begin
            if (out_ready) begin
               if (in_valid) state_d = is_iter ? BUSY : DONE;
               else          state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs; out_ready is the only input reaching in_ready
   always_comb begin
      in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
      out_valid = (state_q == DONE);
   end

   // Datapath updates: operand capture on accept, iteration in BUSY, and a
   // single place where Res and all flags are loaded together
   always_comb begin
      hi_d      = hi_q;
      lo_d      = lo_q;
      opnd_d    = opnd_q;
      mop_d     = mop_q;
      cnt_d     = cnt_q;
      load_res  = 1'b0;
      new_res   = alu_res;
      new_carry = alu_carry;
      new_ovf   = alu_ovf;
      if (accept) begin
         if (is_iter) begin
            hi_d   = '0;
            lo_d   = A;
            opnd_d = B;
            mop_d  = {ALUControl[2], ALUControl[0]};
            cnt_d  = CW'(WIDTH);
         end else begin
            load_res = 1'b1;
         end
      end else if (state_q == BUSY) begin
         hi_d  = hi_n;
         lo_d  = lo_n;
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            load_res  = 1'b1;
            new_res   = iter_res;
            new_carry = 1'b0;
            new_ovf   = 1'b0;
         end
      end
      res_d   = res_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      neg_d   = neg_q;
      if (load_res) begin
         res_d   = new_res;
         carry_d = new_carry;
         ovf_d   = new_ovf;
         zero_d  = (new_res == '0);
         neg_d   = new_res[WIDTH-1];
      end
   end

   assign Res      = res_q;
   assign Carry    = carry_q;
   assign OverFlow = ovf_q;
   assign Zero     = zero_q;
   assign Negative = neg_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Testbench for alu_muldiv: directed vector table, random ops against an
// arithmetic reference model, and hand-written reset/backpressure sequences.
module tb_alu_muldiv;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] A;
   logic [31:0] B;
   logic [3:0]  ALUControl;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] Res;
   logic        Carry;
   logic        OverFlow;
   logic        Zero;
   logic        Negative;

   int testsRun    = 0;
   int testsFailed = 0;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [3:0]  flags;
      int          lat;
   } vec_t;

   typedef struct packed {
      logic [31:0] res;
      logic [3:0]  flags;
   } model_t;

   alu_muldiv #(.WIDTH(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .A          (A),
      .B          (B),
      .ALUControl (ALUControl),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .Res        (Res),
      .Carry      (Carry),
      .OverFlow   (OverFlow),
      .Zero       (Zero),
      .Negative   (Negative)
   );

   // 100 MHz clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value with the expected one and tally the result
   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Reference model: plain arithmetic on the architectural rules, flags {C,V,Z,N}
   function automatic model_t refModel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      model_t      m;
      longint      sa, sb, s;
      logic [63:0] p;
      int          sh;
      logic        c, v;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sh = int'(b) & 31;
      p  = {32'd0, a} * {32'd0, b};
      c  = 1'b0;
      v  = 1'b0;
      m.res = 32'd0;
      case (op)
         4'd0: begin
            m.res = a + b;
            c = ({32'd0, a} + {32'd0, b}) > 64'hFFFF_FFFF;
            s = sa + sb;
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         4'd1: begin
            m.res = a - b;
            c = (a >= b);
            s = sa - sb;
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         4'd2:  m.res = a & b;
         4'd3:  m.res = a | b;
         4'd4:  m.res = a ^ b;
         4'd5:  m.res = (sa < sb) ? 32'd1 : 32'd0;
         4'd6:  m.res = (a < b) ? 32'd1 : 32'd0;
         4'd7:  m.res = a << sh;
         4'd8:  m.res = a >> sh;
         4'd9:  m.res = $signed(a) >>> sh;
         4'd10: m.res = p[31:0];
         4'd11: m.res = p[63:32];
         4'd12: m.res = (b == 0) ? 32'hFFFF_FFFF : a / b;
         4'd13: m.res = (b == 0) ? a : a % b;
         default: m.res = 32'd0;
      endcase
      m.flags = {c, v, (m.res == 32'd0), m.res[31]};
      return m;
   endfunction

   // Issue one op from IDLE, wait (bounded) for the result, then consume it.
   // Operand inputs are scrambled right after accept to prove they were captured.
   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic [3:0] f,
                                output int lat, output logic busyOk);
      in_valid   = 1'b1;
      A          = a;
      B          = b;
      ALUControl = op;
      out_ready  = 1'b0;
      @(posedge clk); #1;
      in_valid   = 1'b0;
      A          = $urandom;
      B          = $urandom;
      ALUControl = 4'($urandom);
      lat        = 1;
      busyOk     = 1'b1;
      while (!out_valid && lat < 100) begin
         if (in_ready) busyOk = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      r = Res;
      f = {Carry, OverFlow, Zero, Negative};
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   vec_t        vecs[22];
   logic [31:0] r;
   logic [3:0]  f;
   int          lat;
   logic        busyOk;
   model_t      exp_m;
   logic [3:0]  rop;
   logic [31:0] ra, rb;
   logic [31:0] heldRes;
   logic [3:0]  heldFlags;

   initial begin
      vecs[0]  = '{4'd0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0101, 1};
      vecs[1]  = '{4'd1,  32'd5,         32'd5,         32'h0000_0000, 4'b1010, 1};
      vecs[2]  = '{4'd1,  32'd3,         32'd5,         32'hFFFF_FFFE, 4'b0001, 1};
      vecs[3]  = '{4'd5,  32'hFFFF_FFFF, 32'd1,         32'd1,         4'b0000, 1};
      vecs[4]  = '{4'd6,  32'hFFFF_FFFF, 32'd1,         32'd0,         4'b0010, 1};
      vecs[5]  = '{4'd9,  32'h8000_0000, 32'h0000_0021, 32'hC000_0000, 4'b0001, 1};
      vecs[6]  = '{4'd7,  32'd1,         32'd31,        32'h8000_0000, 4'b0001, 1};
      vecs[7]  = '{4'd8,  32'h8000_0000, 32'd4,         32'h0800_0000, 4'b0000, 1};
      vecs[8]  = '{4'd2,  32'hF0,        32'h3C,        32'h30,        4'b0000, 1};
      vecs[9]  = '{4'd3,  32'hF0,        32'h0F,        32'hFF,        4'b0000, 1};
      vecs[10] = '{4'd4,  32'hFF00_FF00, 32'hFFFF_FFFF, 32'h00FF_00FF, 4'b0000, 1};
      vecs[11] = '{4'd14, 32'd5,         32'd6,         32'd0,         4'b0010, 1};
      vecs[12] = '{4'd10, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE, 4'b0001, 33};
      vecs[13] = '{4'd11, 32'hFFFF_FFFF, 32'd2,         32'd1,         4'b0000, 33};
      vecs[14] = '{4'd12, 32'd100,       32'd7,         32'd14,        4'b0000, 33};
      vecs[15] = '{4'd13, 32'd100,       32'd7,         32'd2,         4'b0000, 33};
      vecs[16] = '{4'd12, 32'd1234,      32'd0,         32'hFFFF_FFFF, 4'b0001, 33};
      vecs[17] = '{4'd13, 32'd9,         32'd0,         32'd9,         4'b0000, 33};
      vecs[18] = '{4'd0,  32'hFFFF_FFFF, 32'd1,         32'd0,         4'b1010, 1};
      vecs[19] = '{4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         4'b0010, 1};
      vecs[20] = '{4'd1,  32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 4'b1100, 1};
      vecs[21] = '{4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4'b0001, 33};

      rst        = 1'b0;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      A          = '0;
      B          = '0;
      ALUControl = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_out_valid", out_valid, 0);
      checkOutput("reset_res", Res, 0);
      checkOutput("reset_flags", {Carry, OverFlow, Zero, Negative}, 0);
      checkOutput("reset_in_ready", in_ready, 1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;

      // Directed vector table
      for (int i = 0; i < 22; i++) begin
         applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, r, f, lat, busyOk);
         checkOutput($sformatf("vec%0d_res", i), r, vecs[i].res);
         checkOutput($sformatf("vec%0d_flags", i), f, vecs[i].flags);
         checkOutput($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
         if (vecs[i].lat > 1) checkOutput($sformatf("vec%0d_busy_in_ready", i), busyOk, 1);
      end

      // Random ops against the reference model
      for (int i = 0; i < 200; i++) begin
         rop = 4'($urandom_range(0, 15));
         ra  = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = $urandom_range(0, 40);
            1:       rb = $urandom & 32'h0000_FFFF;
            default: rb = $urandom;
         endcase
         exp_m = refModel(rop, ra, rb);
         applyStimulus(rop, ra, rb, r, f, lat, busyOk);
         checkOutput($sformatf("rand%0d_op%0d_res", i, rop), r, exp_m.res);
         checkOutput($sformatf("rand%0d_op%0d_flags", i, rop), f, exp_m.flags);
         checkOutput($sformatf("rand%0d_op%0d_latency", i, rop),
                     lat, (rop >= 4'd10 && rop <= 4'd13) ? 33 : 1);
      end

      // Reset in the middle of a multiply aborts it with no output
      applyStimulus(4'd7, 32'd1, 32'd31, r, f, lat, busyOk);
      in_valid   = 1'b1;
      A          = 32'hFFFF_FFFF;
      B          = 32'd2;
      ALUControl = 4'd10;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checkOutput("midop_busy_in_ready", in_ready, 0);
      rst = 1'b0;
      #1;
      checkOutput("midop_reset_out_valid", out_valid, 0);
      checkOutput("midop_reset_res", Res, 0);
      checkOutput("midop_reset_flags", {Carry, OverFlow, Zero, Negative}, 0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      checkOutput("post_reset_in_ready", in_ready, 1);
      checkOutput("post_reset_out_valid", out_valid, 0);
      applyStimulus(4'd0, 32'd2, 32'd3, r, f, lat, busyOk);
      checkOutput("post_reset_add_res", r, 5);
      checkOutput("post_reset_add_latency", lat, 1);

      // Backpressure: result held for 4 cycles, new in_valid ignored
      in_valid   = 1'b1;
      A          = 32'h7FFF_FFFF;
      B          = 32'd1;
      ALUControl = 4'd0;
      out_ready  = 1'b0;
      @(posedge clk); #1;
      A          = 32'h1234;
      B          = 32'h5678;
      ALUControl = 4'd4;
      heldRes    = 32'h8000_0000;
      heldFlags  = 4'b0101;
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("hold%0d_out_valid", i), out_valid, 1);
         checkOutput($sformatf("hold%0d_in_ready", i), in_ready, 0);
         checkOutput($sformatf("hold%0d_res", i), Res, heldRes);
         checkOutput($sformatf("hold%0d_flags", i), {Carry, OverFlow, Zero, Negative}, heldFlags);
         @(posedge clk); #1;
      end

      // Handoff and accept of a new single-cycle op in the same cycle
      out_ready  = 1'b1;
      A          = 32'hF0;
      B          = 32'h3C;
      ALUControl = 4'd2;
      #1;
      checkOutput("handoff_in_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      checkOutput("b2b_out_valid", out_valid, 1);
      checkOutput("b2b_res", Res, 32'h30);
      checkOutput("b2b_flags", {Carry, OverFlow, Zero, Negative}, 0);

      // Handoff straight into a multiply
      out_ready  = 1'b1;
      in_valid   = 1'b1;
      A          = 32'd3;
      B          = 32'd4;
      ALUControl = 4'd10;
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      checkOutput("b2b_mul_out_valid", out_valid, 0);
      checkOutput("b2b_mul_in_ready", in_ready, 0);
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      checkOutput("b2b_mul_latency", lat, 33);
      checkOutput("b2b_mul_res", Res, 12);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checkOutput("drain_out_valid", out_valid, 0);
      checkOutput("drain_in_ready", in_ready, 1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
Parametrised successor to the pipeline's single-cycle ALU. It executes arithmetic, logic, shift and compare ops in one cycle, and unsigned multiply/divide iteratively. Operands and results move over a valid/ready handshake. It sits in the EX stage; the hazard unit stalls the pipeline while in_ready or out_valid is low.

Parameters:
WIDTH, 32, operand/result width in bits (>= 8, power of 2)
SHW, $clog2(WIDTH), shift-amount bits taken from B (derived, not overridable)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
in_valid  input  1  A/B/ALUControl valid this cycle
in_ready  output  1  block can accept an op this cycle
A  input  WIDTH  operand A
B  input  WIDTH  operand B
ALUControl  input  4  operation select
out_valid  output  1  Res/flags valid
out_ready  input  1  consumer takes result this cycle
Res  output  WIDTH  result
Carry  output  1  carry-out (ADD) / no-borrow (SUB), else 0
OverFlow  output  1  signed overflow (ADD/SUB), else 0
Zero  output  1  Res == 0
Negative  output  1  Res[WIDTH-1]

Behaviour:
- Reset (rst=0, async): state=IDLE; out_valid=0; Res=0; all flags 0; iteration counter=0. Reset mid-multiply/divide aborts the op with no output.
- ALUControl encoding:
  - 0000 ADD; 0001 SUB (A+~B+1); 0010 AND; 0011 OR; 0100 XOR.
  - 0101 SLT (signed; result 1 or 0, zero-extended); 0110 SLTU.
  - 0111 SLL; 1000 SRL; 1001 SRA. Shift amount = B[SHW-1:0].
  - 1010 MUL (low WIDTH bits of A*B); 1011 MULHU (high WIDTH bits, unsigned).
  - 1100 DIVU; 1101 REMU.
  - 1110/1111: Res=0, flags computed from Res, latency 1.
- Flags:
  - Carry = bit WIDTH of the WIDTH+1-bit sum for ADD/SUB.
  - OverFlow = operand signs agree (after B inversion for SUB) and the sum sign differs.
  - Both are 0 for all other ops.
  - Zero and Negative derive from the final Res for every op.
  - All flags are registered together with Res.
- FSM states IDLE, BUSY, DONE:
  - IDLE: in_ready=1. On in_valid, a single-cycle op latches its result and goes to DONE (out_valid the next cycle, latency 1). A mul/div op latches the operands, sets counter=WIDTH and goes to BUSY.
  - BUSY: in_ready=0. One shift-add (mul) or restoring-subtract (div) step per cycle; counter decrements. When counter reaches 1, the final step completes and the state goes to DONE. Total latency from accept to out_valid is WIDTH+1 cycles.
  - DONE: out_valid=1; Res and flags held stable until out_ready. With out_ready=1, in_ready=out_ready, so back-to-back accept is allowed. If in_valid is also 1, the new op is accepted in the same cycle as the handoff: single-cycle op goes DONE with the new result; mul/div goes BUSY. If out_ready=1 and in_valid=0, go to IDLE and drop out_valid. If out_ready=0, hold everything and ignore in_valid.
- Operands are captured only on accept. Later A/B/ALUControl changes do not affect an op in flight.
- Divide by zero: DIVU Res = all ones; REMU Res = A. This takes the same WIDTH+1 latency, so timing is data-independent.
- Multiply and divide are unsigned only. Signed variants are out of scope.
- No combinational path from in_valid or A/B to Res or out_valid. out_ready -> in_ready is the only combinational path.

Test Plan:
1. Reset mid-op: accept MUL, assert rst=0 at cycle 5 -> out_valid=0, Res=0 immediately; after release in_ready=1 and the next ADD 2+3 gives Res=5 after 1 cycle.
2. ADD/SUB flags (WIDTH=32):
   - ADD 0x7FFFFFFF+1 -> Res=0x80000000, OverFlow=1, Negative=1, Carry=0.
   - SUB 5-5 -> Res=0, Zero=1, Carry=1.
   - SUB 3-5 -> Res=0xFFFFFFFE, Carry=0, Negative=1.
3. Compare and shift:
   - SLT 0xFFFFFFFF,1 -> Res=1; SLTU with the same operands -> Res=0.
   - SRA 0x80000000 by B=0x21 -> shifts 1 -> Res=0xC0000000.
   - SLL 1 by 31 -> Res=0x80000000.
4. Multiply: MUL 0xFFFFFFFF*2 -> Res=0xFFFFFFFE; MULHU with the same operands -> Res=1. out_valid is asserted exactly 33 cycles after accept, and in_ready=0 throughout BUSY.
5. Divide: DIVU 100/7 -> Res=14, REMU 100/7 -> Res=2. DIVU x/0 -> Res=0xFFFFFFFF; REMU 9/0 -> Res=9; all after 33 cycles.
6. Backpressure and back-to-back:
   - Hold out_ready=0 for 4 cycles in DONE -> Res/flags stable, new in_valid ignored.
   - Then out_ready=1 with in_valid=1 (AND 0xF0&0x3C) -> handoff and accept in the same cycle; next cycle Res=0x30.
